// File: rtl/rect_cmd_sequencer_if.sv
// rect_cmd_sequencer_if: upstream rectangle command handshake (valid/ready plus x, y, colour payload)
interface rect_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_x;
    logic [6:0] cmd_y;
    logic [2:0] cmd_colour;
    modport master(output cmd_valid, cmd_x, cmd_y, cmd_colour, input cmd_ready);
    modport slave(input cmd_valid, cmd_x, cmd_y, cmd_colour, output cmd_ready);
endinterface

// File: rtl/rect_cmd_sequencer.sv
// rect_cmd_sequencer: queues rectangle commands and sequences ld_x/ld_y/start_count to the draw datapath
module rect_cmd_sequencer #(
    parameter int FIFO_AW     = 2,
    parameter int DRAW_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    rect_cmd_sequencer_if.slave  cmd,
    output logic [6:0]           data_out,
    output logic                 ld_x,
    output logic                 ld_y,
    output logic                 start_count,
    output logic [2:0]           colour_out,
    output logic                 busy,
    output logic [FIFO_AW:0]     pending
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(DRAW_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, START, WAIT} state_t;
    state_t             state, state_nx;
    logic [16:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      cnt;
    logic [6:0]         cmd_x_r, cmd_y_r;
    logic [2:0]         cmd_colour_r;
    logic               push, pop;

    // pending never exceeds DEPTH, so its MSB alone flags a full queue
    assign cmd.cmd_ready = !pending[FIFO_AW];
    assign push = cmd.cmd_valid && cmd.cmd_ready;
    assign pop  = state == IDLE && pending != '0;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {cmd.cmd_x, cmd.cmd_y, cmd.cmd_colour};

    always_ff @(posedge clk)
        if (!resetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pending      <= '0;
            cnt          <= '0;
            cmd_x_r      <= '0;
            cmd_y_r      <= '0;
            cmd_colour_r <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
                {cmd_x_r, cmd_y_r, cmd_colour_r} <= mem[rd_ptr];
            end
            pending <= pending + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
            cnt     <= state == START ? CW'(DRAW_CYCLES - 1) :
                       (state == WAIT && cnt != '0) ? cnt - CW'(1) : cnt;
        end

    always_ff @(posedge clk)
        state <= !resetn ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pop) state_nx = LOAD_X;
            LOAD_X:  state_nx = LOAD_Y;
            LOAD_Y:  state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ld_x        = state == LOAD_X;
        ld_y        = state == LOAD_Y;
        start_count = state == START;
        busy        = state != IDLE;
        data_out    = state == LOAD_X ? cmd_x_r : state == LOAD_Y ? cmd_y_r : '0;
        colour_out  = state != IDLE ? cmd_colour_r : '0;
    end
endmodule

// File: tb/tb_rect_cmd_sequencer.sv
// tb_rect_cmd_sequencer: directed scenario tests for rect_cmd_sequencer with hand-computed expectations
module tb_rect_cmd_sequencer;
    logic       clk = 0;
    logic       resetn;
    logic [6:0] data_out;
    logic       ld_x, ld_y, start_count, busy;
    logic [2:0] colour_out;
    logic [2:0] pending;
    int         checks = 0, passes = 0, cyc = 0, ldx_count = 0;
    logic [6:0] seen [$];
    int         ld_cyc [$];

    rect_cmd_sequencer_if bus();

    rect_cmd_sequencer #(.FIFO_AW(2), .DRAW_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn), .cmd(bus), .data_out(data_out), .ld_x(ld_x), .ld_y(ld_y),
        .start_count(start_count), .colour_out(colour_out), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;

    // strobe exclusivity on every cycle, plus a log of every ld_x issued
    always @(negedge clk) begin
        cyc++;
        checks++;
        if (int'(ld_x) + int'(ld_y) + int'(start_count) > 1)
            $display("FAIL strobe_exclusive: ld_x=%b ld_y=%b start_count=%b at cycle %0d", ld_x, ld_y, start_count, cyc);
        else passes++;
        if (ld_x === 1'b1) begin
            seen.push_back(data_out);
            ld_cyc.push_back(cyc);
            ldx_count++;
        end
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [6:0] x, input logic [6:0] y, input logic [2:0] c);
        bus.cmd_valid = 1; bus.cmd_x = x; bus.cmd_y = y; bus.cmd_colour = c;
        tick();
        bus.cmd_valid = 0;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while ((busy || pending != 0) && n < limit) begin tick(); n++; end
        checks++;
        if (n >= limit) $display("FAIL %s_timeout: still busy after %0d cycles", name, n); else passes++;
    endtask

    task automatic test_reset;
        resetn = 0; bus.cmd_valid = 1; bus.cmd_x = 7'd5; bus.cmd_y = 7'd6; bus.cmd_colour = 3'd7;
        repeat (3) tick();
        bus.cmd_valid = 0; resetn = 1;
        checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); else passes++;
        checks++; if ({busy, ld_x, ld_y, start_count, data_out, colour_out, pending} !== 16'd0)
            $display("FAIL reset_outputs: got busy=%b ldx=%b ldy=%b sc=%b data=%0d col=%0d pend=%0d want all 0", busy, ld_x, ld_y, start_count, data_out, colour_out, pending);
        else passes++;
        tick();
        checks++; if ({busy, pending} !== 4'd0) $display("FAIL reset_push_ignored: got busy=%b pending=%0d want 0 0", busy, pending); else passes++;
    endtask

    task automatic test_single;
        seen.delete();
        push_one(7'd10, 7'd20, 3'd3);
        checks++; if ({pending, busy, ld_x} !== {3'd1, 1'b0, 1'b0}) $display("FAIL single_c1: got pend=%0d busy=%b ldx=%b want 1 0 0", pending, busy, ld_x); else passes++;
        tick();
        checks++; if ({ld_x, data_out, busy, colour_out, pending} !== {1'b1, 7'd10, 1'b1, 3'd3, 3'd0})
            $display("FAIL single_ldx: got ldx=%b data=%0d busy=%b col=%0d pend=%0d want 1 10 1 3 0", ld_x, data_out, busy, colour_out, pending);
        else passes++;
        tick();
        checks++; if ({ld_x, ld_y, data_out, colour_out} !== {1'b0, 1'b1, 7'd20, 3'd3})
            $display("FAIL single_ldy: got ldx=%b ldy=%b data=%0d col=%0d want 0 1 20 3", ld_x, ld_y, data_out, colour_out);
        else passes++;
        tick();
        checks++; if ({ld_y, start_count, data_out, colour_out} !== {1'b0, 1'b1, 7'd0, 3'd3})
            $display("FAIL single_start: got ldy=%b sc=%b data=%0d col=%0d want 0 1 0 3", ld_y, start_count, data_out, colour_out);
        else passes++;
        for (int c = 5; c <= 20; c++) begin
            tick();
            checks++; if ({busy, ld_x, ld_y, start_count, data_out, colour_out} !== {1'b1, 3'b000, 7'd0, 3'd3})
                $display("FAIL single_wait_c%0d: got busy=%b strobes=%b%b%b data=%0d col=%0d want 1 000 0 3", c, busy, ld_x, ld_y, start_count, data_out, colour_out);
            else passes++;
        end
        tick();
        checks++; if ({busy, colour_out} !== 4'd0) $display("FAIL single_done_c21: got busy=%b col=%0d want 0 0", busy, colour_out); else passes++;
        checks++; if (seen.size() !== 1) $display("FAIL single_ldx_count: got %0d want 1", seen.size()); else passes++;
    endtask

    task automatic test_fill;
        seen.delete();
        for (int i = 0; i < 6; i++) begin
            bus.cmd_valid = 1; bus.cmd_x = 7'(i + 1); bus.cmd_y = 7'(i + 40); bus.cmd_colour = 3'(i);
            checks++; if (bus.cmd_ready !== 1'(i < 5)) $display("FAIL fill_ready_%0d: got %b want %b", i, bus.cmd_ready, 1'(i < 5)); else passes++;
            tick();
        end
        bus.cmd_valid = 0;
        checks++; if ({pending, bus.cmd_ready} !== {3'd4, 1'b0}) $display("FAIL fill_full: got pend=%0d ready=%b want 4 0", pending, bus.cmd_ready); else passes++;
        wait_idle(300, "fill");
        checks++; if (seen.size() !== 5) $display("FAIL fill_count: got %0d want 5", seen.size()); else passes++;
        for (int i = 0; i < seen.size() && i < 5; i++) begin
            checks++; if (seen[i] !== 7'(i + 1)) $display("FAIL fill_order_%0d: got %0d want %0d", i, seen[i], i + 1); else passes++;
        end
    endtask

    task automatic test_order_wrap;
        int n;
        seen.delete(); ld_cyc.delete();
        for (int i = 1; i <= 9; i++) begin
            bus.cmd_valid = 1; bus.cmd_x = 7'(i); bus.cmd_y = 7'(i + 60); bus.cmd_colour = 3'(i);
            n = 0;
            while (!bus.cmd_ready && n < 40) begin tick(); n++; end
            tick();
            bus.cmd_valid = 0;
            checks++; if (n >= 40) $display("FAIL wrap_ready_timeout_%0d: got ready=0 want 1 within 40 cycles", i); else passes++;
        end
        wait_idle(400, "wrap");
        checks++; if (seen.size() !== 9) $display("FAIL wrap_count: got %0d want 9", seen.size()); else passes++;
        for (int i = 0; i < seen.size() && i < 9; i++) begin
            checks++; if (seen[i] !== 7'(i + 1)) $display("FAIL wrap_order_%0d: got %0d want %0d", i, seen[i], i + 1); else passes++;
            if (i > 0) begin
                checks++; if (ld_cyc[i] - ld_cyc[i-1] !== 20) $display("FAIL wrap_spacing_%0d: got %0d want 20", i, ld_cyc[i] - ld_cyc[i-1]); else passes++;
            end
        end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        seen.delete();
        push_one(7'd21, 7'd1, 3'd1);
        push_one(7'd22, 7'd2, 3'd2);
        push_one(7'd23, 7'd3, 3'd3);
        while (busy && n < 40) begin tick(); n++; end
        checks++; if ({busy, pending} !== {1'b0, 3'd2}) $display("FAIL b2b_pop_cycle: got busy=%b pend=%0d want 0 2", busy, pending); else passes++;
        push_one(7'd24, 7'd4, 3'd4);
        checks++; if ({pending, ld_x, data_out, colour_out} !== {3'd2, 1'b1, 7'd22, 3'd2})
            $display("FAIL b2b_push_pop: got pend=%0d ldx=%b data=%0d col=%0d want 2 1 22 2", pending, ld_x, data_out, colour_out);
        else passes++;
        wait_idle(200, "b2b");
        checks++; if (seen.size() !== 4) $display("FAIL b2b_count: got %0d want 4", seen.size()); else passes++;
        for (int i = 0; i < seen.size() && i < 4; i++) begin
            checks++; if (seen[i] !== 7'(21 + i)) $display("FAIL b2b_order_%0d: got %0d want %0d", i, seen[i], 21 + i); else passes++;
        end
    endtask

    task automatic test_mid_reset;
        int base;
        push_one(7'd30, 7'd1, 3'd5);
        push_one(7'd31, 7'd2, 3'd5);
        push_one(7'd32, 7'd3, 3'd5);
        push_one(7'd33, 7'd4, 3'd5);
        repeat (2) tick();
        checks++; if ({busy, pending, ld_x, ld_y, start_count, colour_out} !== {1'b1, 3'd3, 3'b000, 3'd5})
            $display("FAIL midrst_wait: got busy=%b pend=%0d strobes=%b%b%b col=%0d want 1 3 000 5", busy, pending, ld_x, ld_y, start_count, colour_out);
        else passes++;
        resetn = 0; bus.cmd_valid = 1; bus.cmd_x = 7'd99;
        tick();
        bus.cmd_valid = 0; resetn = 1;
        checks++; if ({busy, pending, ld_x, ld_y, start_count, data_out, colour_out, bus.cmd_ready} !== {14'd0, 3'd0, 1'b1})
            $display("FAIL midrst_after: got busy=%b pend=%0d strobes=%b%b%b data=%0d col=%0d ready=%b want all 0 ready 1", busy, pending, ld_x, ld_y, start_count, data_out, colour_out, bus.cmd_ready);
        else passes++;
        base = ldx_count;
        repeat (60) tick();
        checks++; if (ldx_count !== base) $display("FAIL midrst_no_ldx: got %0d extra ld_x want 0", ldx_count - base); else passes++;
        checks++; if ({busy, pending} !== 4'd0) $display("FAIL midrst_idle: got busy=%b pend=%0d want 0 0", busy, pending); else passes++;
    endtask

    initial begin
        bus.cmd_valid = 0; bus.cmd_x = 0; bus.cmd_y = 0; bus.cmd_colour = 0; resetn = 0;
        test_reset();
        test_single();
        test_fill();
        test_order_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
